// File: rtl/adder_rr_arbiter.sv
// ============================================================================
// Module   : adder_rr_arbiter
// Purpose  : Round-robin sharing of one combinational adder among NUM_REQ
//            requesters, returning sum and requester ID on a response channel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_rr_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  localparam int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [DATA_WIDTH-1:0]         adder_a,
  output logic [DATA_WIDTH-1:0]         adder_b,
  input  logic [DATA_WIDTH-1:0]         adder_o,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic                          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q;
  logic [DATA_WIDTH-1:0] adder_a_q, adder_b_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic [ID_WIDTH-1:0]   rsp_id_q;

  logic [DATA_WIDTH-1:0] op_a [NUM_REQ];
  logic [DATA_WIDTH-1:0] op_b [NUM_REQ];
  logic                  grant_found;
  logic [ID_WIDTH-1:0]   grant_idx;
  logic [ID_WIDTH-1:0]   cand;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign op_a[gi] = req_a[gi*DATA_WIDTH +: DATA_WIDTH];
    assign op_b[gi] = req_b[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Search starts just past the last winner, so that winner ranks lowest.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_WIDTH'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          state_d = EXEC;
          if (rst) begin
            req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx;
          end
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q    <= ID_WIDTH'(NUM_REQ - 1);
      adder_a_q   <= '0;
      adder_b_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            adder_a_q <= op_a[grant_idx];
            adder_b_q <= op_b[grant_idx];
            rsp_id_q  <= grant_idx;
            rr_ptr_q  <= grant_idx;
          end
        end
        EXEC: begin
          rsp_data_q  <= adder_o;
          rsp_valid_q <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign adder_a   = adder_a_q;
  assign adder_b   = adder_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_adder_rr_arbiter.sv
// ============================================================================
// Module   : tb_adder_rr_arbiter
// Purpose  : Directed self-checking bench for adder_rr_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_rr_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [W-1:0]   adder_a;
  logic [W-1:0]   adder_b;
  logic [W-1:0]   adder_o;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_data;
  logic [1:0]     rsp_id;
  logic           busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Adder model sitting on the far side of the adder port.
  assign adder_o = adder_a + adder_b;

  adder_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .adder_a   (adder_a),
    .adder_b   (adder_b),
    .adder_o   (adder_o),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    req_valid = '0;
    cyc();
    cyc();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_rsp();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (rsp_valid === 1'b1) seen = 1'b1;
      else cyc();
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL rsp_timeout: rsp_valid=%0b required 1 within 20 cycles", rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    rsp_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
    set_op(0, 8'd3, 8'd5);
    req_valid = 4'b0001;
    #1;
    cyc();
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready: got %b required 0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (adder_a !== 8'd0 || adder_b !== 8'd0) begin failures++; $display("FAIL reset_adder_ops: got a=%0d b=%0d required 0 0", adder_a, adder_b); end
    checks++; if (rsp_data !== 8'd0 || rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp_fields: got data=%0d id=%0d required 0 0", rsp_data, rsp_id); end
    req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL basic_grant: got %b required 0001", req_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_idle_busy: got %b required 0", busy); end
    cyc();
    req_valid = '0;
    #1;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL basic_ready_one_cycle: got %b required 0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL basic_exec: got valid=%b busy=%b required 0 1", rsp_valid, busy); end
    checks++; if (adder_a !== 8'd3 || adder_b !== 8'd5) begin failures++; $display("FAIL basic_operands: got a=%0d b=%0d required 3 5", adder_a, adder_b); end
    cyc();
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL basic_latency: got rsp_valid=%b required 1", rsp_valid); end
    checks++; if (rsp_data !== 8'd8 || rsp_id !== 2'd0) begin failures++; $display("FAIL basic_result: got data=%0d id=%0d required 8 0", rsp_data, rsp_id); end
    cyc();
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL basic_one_cycle_rsp: got valid=%b busy=%b required 0 0", rsp_valid, busy); end
  endtask

  task automatic test_wrap();
    set_op(2, 8'd200, 8'd100);
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL wrap_grant: got %b required 0100", req_ready); end
    cyc();
    req_valid = '0;
    wait_rsp();
    checks++; if (rsp_data !== 8'd44 || rsp_id !== 2'd2) begin failures++; $display("FAIL wrap_result: got data=%0d id=%0d required 44 2", rsp_data, rsp_id); end
    cyc();
  endtask

  task automatic test_all_valid();
    int exp_id [5];
    int g, n, last;
    exp_id = '{0, 1, 2, 3, 0};
    g = 0; n = 0; last = 0;
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, W'(i), W'(10 * i));
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    #1;
    for (int c = 0; c < 60 && n < 5; c++) begin
      if (req_ready !== 4'b0000 && g < 5) begin
        checks++;
        if (req_ready !== (4'b0001 << exp_id[g])) begin failures++; $display("FAIL rr_grant%0d: got %b required id %0d", g, req_ready, exp_id[g]); end
        if (g > 0) begin
          checks++;
          if (c - last !== 3) begin failures++; $display("FAIL rr_spacing%0d: got %0d cycles required 3", g, c - last); end
        end
        last = c;
        g++;
      end
      if (rsp_valid === 1'b1) begin
        checks++;
        if (rsp_id !== 2'(exp_id[n]) || rsp_data !== W'(11 * exp_id[n])) begin
          failures++;
          $display("FAIL rr_rsp%0d: got id=%0d data=%0d required id=%0d data=%0d", n, rsp_id, rsp_data, exp_id[n], 11 * exp_id[n]);
        end
        n++;
      end
      if (n < 5) cyc();
    end
    checks++; if (n !== 5) begin failures++; $display("FAIL rr_count: got %0d responses required 5", n); end
    req_valid = '0;
    cyc();
  endtask

  task automatic test_stall();
    set_op(1, 8'd7, 8'd9);
    set_op(2, 8'd20, 8'd22);
    rsp_ready = 1'b0;
    req_valid = 4'b0110;
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL stall_grant: got %b required 0010", req_ready); end
    cyc();
    req_valid = 4'b0100;
    cyc();
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'd16 || rsp_id !== 2'd1 || req_ready !== 4'b0000 || busy !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold%0d: got valid=%b data=%0d id=%0d ready=%b busy=%b required 1 16 1 0000 1",
                 k, rsp_valid, rsp_data, rsp_id, req_ready, busy);
      end
      cyc();
    end
    rsp_ready = 1'b1;
    cyc();
    checks++; if (req_ready !== 4'b0100 || rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL stall_release: got ready=%b valid=%b busy=%b required 0100 0 0", req_ready, rsp_valid, busy); end
    cyc();
    req_valid = '0;
    checks++; if (busy !== 1'b1 || adder_a !== 8'd20) begin failures++; $display("FAIL stall_next_grant: got busy=%b a=%0d required 1 20", busy, adder_a); end
    wait_rsp();
    checks++; if (rsp_data !== 8'd42 || rsp_id !== 2'd2) begin failures++; $display("FAIL stall_next_rsp: got data=%0d id=%0d required 42 2", rsp_data, rsp_id); end
    cyc();
  endtask

  task automatic test_reset_mid();
    set_op(3, 8'd50, 8'd60);
    req_valid = 4'b1000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL rmid_grant: got %b required 1000", req_ready); end
    cyc();
    req_valid = '0;
    checks++; if (busy !== 1'b1 || adder_a !== 8'd50) begin failures++; $display("FAIL rmid_exec: got busy=%b a=%0d required 1 50", busy, adder_a); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rmid_async: got valid=%b busy=%b required 0 0", rsp_valid, busy); end
    checks++; if (adder_a !== 8'd0 || adder_b !== 8'd0) begin failures++; $display("FAIL rmid_ops: got a=%0d b=%0d required 0 0", adder_a, adder_b); end
    cyc();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin failures++; $display("FAIL rmid_no_rsp: got valid=%b ready=%b required 0 0000", rsp_valid, req_ready); end
    set_op(0, 8'd1, 8'd2);
    req_valid = 4'b1001;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL rmid_ptr_reset: got %b required 0001", req_ready); end
    cyc();
    req_valid = 4'b1000;
    wait_rsp();
    checks++; if (rsp_data !== 8'd3 || rsp_id !== 2'd0) begin failures++; $display("FAIL rmid_rsp: got data=%0d id=%0d required 3 0", rsp_data, rsp_id); end
    cyc();
  endtask

  task automatic test_drop();
    checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL drop_grant3: got %b required 1000", req_ready); end
    cyc();
    req_valid = 4'b1010;
    #1;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL drop_exec_ready: got %b required 0000", req_ready); end
    cyc();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 8'd110 || req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL drop_rsp3: got valid=%b id=%0d data=%0d ready=%b required 1 3 110 0000", rsp_valid, rsp_id, rsp_data, req_ready);
    end
    req_valid = '0;
    cyc();
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL drop_quiet%0d: got ready=%b valid=%b busy=%b required 0000 0 0", k, req_ready, rsp_valid, busy);
      end
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_all_valid();
    test_stall();
    test_reset_mid();
    test_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
